inv_sub_bytes_engine: RTL and testbench

Sequential AES InvSubBytes unit for the decryption datapath: accepts a 128-bit state over a valid/ready handshake and applies the inverse S-box to every byte using a small number of shared inverse S-box lookups, several bytes per cycle. It is the decrypt-side counterpart of the combinational subBytes stage. It sits between the inverse-ShiftRows and AddRoundKey stages of the round controller and trades latency for area.

---
 rtl/inv_sub_bytes_engine.sv | 139 +++++++++++++
 tb/tb_inv_sub_bytes_engine.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_engine.sv
// Sequential AES InvSubBytes engine: accepts a 128-bit state, substitutes
// BYTES_PER_CYCLE bytes per cycle through shared inverse S-box lookups and
// presents the result on a valid/ready output that holds until taken.
module inv_sub_bytes_engine #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out
);

  localparam int N  = 16 / BYTES_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_K = CW'(N - 1);

  // FIPS-197 inverse S-box, indexed by the input byte
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [127:0]  work_q, work_d;
  logic [127:0]  data_out_q, data_out_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [127:0]  subst_s;

  // Working state with the current byte group passed through the lookups;
  // lookup inputs only see the working register while BUSY.
  always_comb begin
    subst_s = work_q;
    if (state_q == BUSY) begin
      for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
        subst_s[127 - 8*(int'(cnt_q)*BYTES_PER_CYCLE + j) -: 8] =
          inv_sbox(work_q[127 - 8*(int'(cnt_q)*BYTES_PER_CYCLE + j) -: 8]);
      end
    end else begin
      subst_s = work_q;
    end
  end

  // Next-state logic for the IDLE/BUSY/DONE sequencer and its datapath
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    data_out_d = data_out_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          work_d  = data_in;
          cnt_d   = {CW{1'b0}};
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        work_d = subst_s;
        if (cnt_q == LAST_K) begin
          data_out_d = subst_s;
          cnt_d      = {CW{1'b0}};
          state_d    = DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Handshake flags are registered copies of the upcoming state
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State, datapath and registered handshake outputs; reset discards any block
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      work_q      <= 128'h0;
      data_out_q  <= 128'h0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      data_out_q  <= data_out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_inv_sub_bytes_engine.sv
// Self-checking bench for inv_sub_bytes_engine: a B=4 unit under full test
// plus B=1/2/8/16 units for latency and correctness across group sizes.
// The expected inverse S-box is derived from GF(2^8) inversion + affine map.
module tb_inv_sub_bytes_engine;

  logic         clk;
  logic         n_rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;

  logic         alt_iv;
  logic         alt_or;
  logic [127:0] alt_din;
  logic [3:0]   alt_ir;
  logic [3:0]   alt_ov;
  logic [127:0] alt_dout [4];

  int n_cmp;
  int n_err;

  logic [7:0] inv_tab [256];

  localparam logic [127:0] KNOWN_IN   = 128'h8f92a04dfbed204d4c39b1402192a84c;
  localparam logic [127:0] KNOWN_OUT  = 128'h73744765635354655d5b56727b746f5d;
  localparam logic [127:0] BOUND_IN   = 128'h63007c16_63007c16_63007c16_63007c16;
  localparam logic [127:0] BOUND_OUT  = 128'h005201ff_005201ff_005201ff_005201ff;

  inv_sub_bytes_engine #(.BYTES_PER_CYCLE(4)) dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out)
  );

  for (genvar g = 0; g < 4; g++) begin : g_alt
    inv_sub_bytes_engine #(.BYTES_PER_CYCLE((g < 2) ? (1 << g) : (1 << (g + 1)))) u_alt (
      .clk(clk), .n_rst(n_rst), .in_valid(alt_iv), .in_ready(alt_ir[g]),
      .data_in(alt_din), .out_valid(alt_ov[g]), .out_ready(alt_or), .data_out(alt_dout[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] r;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    s = inv;
    r = inv;
    for (int k = 0; k < 4; k++) begin
      r = rotl1(r);
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) inv_tab[fwd_sbox(8'(x))] = 8'(x);
  endtask

  function automatic logic [127:0] ref_inv(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = inv_tab[d[127 - 8*i -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Stimulus helper: called #1 after an edge with the B=4 unit idle. Presents
  // one block, then waits (bounded) for out_valid, reporting latency in cycles
  // from the accept edge and whether in_ready was seen high meanwhile.
  task automatic send_and_wait(input logic [127:0] d, output int lat, output bit rdy_seen);
    data_in  = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    data_in  = rnd128();
    lat      = 0;
    rdy_seen = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (in_ready) rdy_seen = 1'b1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_rst = 1'b0;
    #12;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (data_out !== 128'h0) begin n_err++; $display("FAIL reset_data_out: got %h want 0", data_out); end
    #5 n_rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_known_vector();
    int lat;
    bit rdy;
    send_and_wait(KNOWN_IN, lat, rdy);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL known_latency: got %0d want 4", lat); end
    n_cmp++; if (data_out !== KNOWN_OUT) begin n_err++; $display("FAIL known_data: got %h want %h", data_out, KNOWN_OUT); end
    n_cmp++; if (data_out !== ref_inv(KNOWN_IN)) begin n_err++; $display("FAIL known_model: got %h want %h", data_out, ref_inv(KNOWN_IN)); end
    n_cmp++; if (rdy !== 1'b0) begin n_err++; $display("FAIL known_ready_busy: got %b want 0", rdy); end
    drain();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL known_release_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL known_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_boundary();
    int lat;
    bit rdy;
    int alat [4];
    bit got [4];
    logic [127:0] ares [4];
    int exp_lat [4];
    logic [127:0] vec;
    exp_lat = '{16, 8, 2, 1};
    send_and_wait(BOUND_IN, lat, rdy);
    n_cmp++; if (data_out !== BOUND_OUT) begin n_err++; $display("FAIL boundary_b4: got %h want %h", data_out, BOUND_OUT); end
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL boundary_b4_latency: got %0d want 4", lat); end
    drain();
    for (int v = 0; v < 2; v++) begin
      vec = (v == 0) ? BOUND_IN : rnd128();
      for (int g = 0; g < 4; g++) begin alat[g] = 0; got[g] = 1'b0; ares[g] = 128'h0; end
      alt_din = vec;
      alt_iv  = 1'b1;
      @(posedge clk); #1;
      alt_iv  = 1'b0;
      alt_din = rnd128();
      for (int c = 1; c <= 24; c++) begin
        @(posedge clk); #1;
        for (int g = 0; g < 4; g++) begin
          if (!got[g] && alt_ov[g]) begin got[g] = 1'b1; alat[g] = c; ares[g] = alt_dout[g]; end
        end
      end
      for (int g = 0; g < 4; g++) begin
        n_cmp++; if (alat[g] !== exp_lat[g]) begin n_err++; $display("FAIL width%0d_latency: got %0d want %0d", g, alat[g], exp_lat[g]); end
        n_cmp++; if (ares[g] !== ref_inv(vec)) begin n_err++; $display("FAIL width%0d_data: got %h want %h", g, ares[g], ref_inv(vec)); end
      end
      if (v == 0) begin
        n_cmp++; if (ares[0] !== BOUND_OUT) begin n_err++; $display("FAIL boundary_b1_const: got %h want %h", ares[0], BOUND_OUT); end
      end
    end
  endtask

  task automatic test_random();
    int lat;
    bit rdy;
    logic [127:0] d;
    for (int i = 0; i < 6; i++) begin
      d = rnd128();
      send_and_wait(d, lat, rdy);
      n_cmp++; if (data_out !== ref_inv(d)) begin n_err++; $display("FAIL random%0d_data: got %h want %h", i, data_out, ref_inv(d)); end
      n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL random%0d_latency: got %0d want 4", i, lat); end
      drain();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit rdy;
    logic [127:0] a;
    logic [127:0] exp_a;
    a = rnd128();
    exp_a = ref_inv(a);
    send_and_wait(a, lat, rdy);
    in_valid = 1'b1;
    data_in  = rnd128();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_c%0d: got %b want 1", c, out_valid); end
      n_cmp++; if (data_out !== exp_a) begin n_err++; $display("FAIL bp_data_c%0d: got %h want %h", c, data_out, exp_a); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_c%0d: got %b want 0", c, in_ready); end
    end
    in_valid = 1'b0;
    drain();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_no_capture_c%0d: got %b want 0", c, out_valid); end
    end
    n_cmp++; if (data_out !== exp_a) begin n_err++; $display("FAIL bp_hold_after: got %h want %h", data_out, exp_a); end
  endtask

  task automatic test_back_to_back();
    int acc [$];
    logic [127:0] res [$];
    logic [127:0] a;
    logic [127:0] b;
    bit will_acc;
    a = rnd128();
    b = rnd128();
    data_in   = a;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      will_acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (will_acc) begin
        acc.push_back(c);
        if (acc.size() == 1) data_in = b;
        else in_valid = 1'b0;
      end
      if (out_valid) res.push_back(data_out);
      else if (res.size() == 1) begin
        n_cmp++; if (data_out !== ref_inv(a)) begin n_err++; $display("FAIL b2b_hold_c%0d: got %h want %h", c, data_out, ref_inv(a)); end
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_cmp++; if (acc.size() !== 2) begin n_err++; $display("FAIL b2b_accepts: got %0d want 2", acc.size()); end
    n_cmp++; if (res.size() !== 2) begin n_err++; $display("FAIL b2b_results: got %0d want 2", res.size()); end
    if (acc.size() >= 2) begin
      n_cmp++; if (acc[1] - acc[0] !== 6) begin n_err++; $display("FAIL b2b_spacing: got %0d want 6", acc[1] - acc[0]); end
    end
    if (res.size() >= 2) begin
      n_cmp++; if (res[0] !== ref_inv(a)) begin n_err++; $display("FAIL b2b_first: got %h want %h", res[0], ref_inv(a)); end
      n_cmp++; if (res[1] !== ref_inv(b)) begin n_err++; $display("FAIL b2b_second: got %h want %h", res[1], ref_inv(b)); end
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit rdy;
    bit stray;
    logic [127:0] d;
    data_in  = rnd128();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    n_rst = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    n_cmp++; if (data_out !== 128'h0) begin n_err++; $display("FAIL midrst_data: got %h want 0", data_out); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL midrst_ready: got %b want 0", in_ready); end
    #10 n_rst = 1'b1;
    stray = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid) stray = 1'b1;
    end
    n_cmp++; if (stray !== 1'b0) begin n_err++; $display("FAIL midrst_stray_valid: got %b want 0", stray); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready_after: got %b want 1", in_ready); end
    d = rnd128();
    send_and_wait(d, lat, rdy);
    n_cmp++; if (data_out !== ref_inv(d)) begin n_err++; $display("FAIL midrst_next_data: got %h want %h", data_out, ref_inv(d)); end
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL midrst_next_latency: got %0d want 4", lat); end
    drain();
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    n_rst     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = 128'h0;
    alt_iv    = 1'b0;
    alt_or    = 1'b1;
    alt_din   = 128'h0;
    build_tables();
    test_reset();
    test_known_vector();
    test_boundary();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
